// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard/stall/flush control beside IF/ID for the 5-stage 20-bit core
module pipe_hazard_ctrl #(
    parameter int unsigned MUL_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] id_instr,
    input  logic        ex_mem_read,
    input  logic [3:0]  ex_rd,
    input  logic        ex_branch_taken,
    output logic        pc_write_en,
    output logic        ifid_write_en,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        mul_busy,
    output logic        halted,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MUL_BUSY = 2'd1,
        HALTED   = 2'd2
    } state_t;

    localparam logic [3:0]  OP_LOAD  = 4'h8;
    localparam logic [3:0]  OP_MUL   = 4'hA;
    localparam logic [3:0]  OP_HALT  = 4'hF;
    localparam logic [3:0]  MUL_LOAD = 4'(MUL_CYCLES - 1);
    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    state_t      state;
    state_t      next_state;
    logic [3:0]  mul_cnt;
    logic [3:0]  next_mul_cnt;

    logic [3:0]  id_op;
    logic [3:0]  id_rs1;
    logic [3:0]  id_rs2;
    logic        rs2_used;
    logic        load_use;
    logic        stall_inc;

    assign id_op  = id_instr[19:16];
    assign id_rs1 = id_instr[11:8];
    assign id_rs2 = id_instr[7:4];

    // LOAD and HALT carry no rs2 operand, so a match on that field is not a hazard.
    assign rs2_used = (id_op != OP_LOAD) && (id_op != OP_HALT);
    assign load_use = ex_mem_read && (ex_rd != 4'd0) &&
                      ((ex_rd == id_rs1) || (rs2_used && (ex_rd == id_rs2)));

    always_comb begin
        next_state    = state;
        next_mul_cnt  = mul_cnt;
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;

        if (rst) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_bubble   = 1'b1;
            next_state    = RUN;
            next_mul_cnt  = 4'd0;
        end else if (state == HALTED) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_bubble   = 1'b1;
        end else if (ex_branch_taken) begin
            // Squash wins over anything decoded in ID, including a pending MUL drain.
            ifid_flush    = 1'b1;
            idex_bubble   = 1'b1;
            next_state    = RUN;
            next_mul_cnt  = 4'd0;
        end else if (state == MUL_BUSY) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_bubble   = 1'b1;
            if (mul_cnt <= 4'd1) begin
                next_state   = RUN;
                next_mul_cnt = 4'd0;
            end else begin
                next_mul_cnt = mul_cnt - 4'd1;
            end
        end else if (load_use) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_bubble   = 1'b1;
        end else if (id_op == OP_HALT) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_bubble   = 1'b1;
            next_state    = HALTED;
        end else if (id_op == OP_MUL) begin
            next_state    = MUL_BUSY;
            next_mul_cnt  = MUL_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        state   <= next_state;
        mul_cnt <= next_mul_cnt;
    end

    // The HALT-decode cycle is still in RUN, so it is counted; HALTED cycles are not.
    assign stall_inc = !rst && !pc_write_en && (state != HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 16'd0;
        end else if (stall_inc && (stall_cycles != STALL_MAX)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

    assign mul_busy = (state == MUL_BUSY);
    assign halted   = (state == HALTED);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int MUL_CYCLES = 3;

    logic        clk;
    logic        rst;
    logic [19:0] id_instr;
    logic        ex_mem_read;
    logic [3:0]  ex_rd;
    logic        ex_branch_taken;
    logic        pc_write_en;
    logic        ifid_write_en;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        mul_busy;
    logic        halted;
    logic [15:0] stall_cycles;

    pipe_hazard_ctrl #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_instr        (id_instr),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .pc_write_en     (pc_write_en),
        .ifid_write_en   (ifid_write_en),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .mul_busy        (mul_busy),
        .halted          (halted),
        .stall_cycles    (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: halted flag, remaining MUL drain cycles, stall count.
    bit m_halted = 1'b0;
    int m_busy_left = 0;
    int m_stalls = 0;

    typedef struct {
        logic [19:0] instr;
        logic        mr;
        logic [3:0]  rd;
        logic        br;
        logic [3:0]  exp_ctl;   // {pc_write_en, ifid_write_en, ifid_flush, idex_bubble}
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_load_use();
        int op, r1, r2;
        bit uses_rs2;
        op = int'(id_instr) / 65536;
        r1 = (int'(id_instr) / 256) % 16;
        r2 = (int'(id_instr) / 16) % 16;
        uses_rs2 = !(op == 8 || op == 15);
        if (!ex_mem_read || ex_rd == 0) return 1'b0;
        return (int'(ex_rd) == r1) || (uses_rs2 && int'(ex_rd) == r2);
    endfunction

    function automatic logic [3:0] model_ctl();
        int op;
        op = int'(id_instr) / 65536;
        if (rst)               return 4'b0001;
        if (m_halted)          return 4'b0001;
        if (ex_branch_taken)   return 4'b1111;
        if (m_busy_left > 0)   return 4'b0001;
        if (model_load_use())  return 4'b0001;
        if (op == 15)          return 4'b0001;
        return 4'b1100;
    endfunction

    task automatic drive(input logic r, input logic [19:0] ins, input logic mr,
                         input logic [3:0] rd, input logic br);
        rst = r;
        id_instr = ins;
        ex_mem_read = mr;
        ex_rd = rd;
        ex_branch_taken = br;
        #1;
    endtask

    task automatic check_model();
        logic [3:0] e;
        e = model_ctl();
        chk("pc_write_en",   32'(pc_write_en),   32'(e[3]));
        chk("ifid_write_en", 32'(ifid_write_en), 32'(e[2]));
        chk("ifid_flush",    32'(ifid_flush),    32'(e[1]));
        chk("idex_bubble",   32'(idex_bubble),   32'(e[0]));
        chk("mul_busy",      32'(mul_busy),      32'(m_busy_left > 0));
        chk("halted",        32'(halted),        32'(m_halted));
        chk("stall_cycles",  32'(stall_cycles),  32'(m_stalls));
    endtask

    task automatic tick();
        logic [3:0] e;
        bit lu;
        int op;
        e = model_ctl();
        lu = model_load_use();
        op = int'(id_instr) / 65536;
        @(posedge clk);
        if (rst) begin
            m_halted = 1'b0;
            m_busy_left = 0;
            m_stalls = 0;
        end else begin
            if (!m_halted && !e[3] && m_stalls < 65535) m_stalls++;
            if (m_halted) begin
            end else if (ex_branch_taken) begin
                m_busy_left = 0;
            end else if (m_busy_left > 0) begin
                m_busy_left--;
            end else if (lu) begin
            end else if (op == 15) begin
                m_halted = 1'b1;
            end else if (op == 10) begin
                m_busy_left = MUL_CYCLES - 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic step(input logic r, input logic [19:0] ins, input logic mr,
                        input logic [3:0] rd, input logic br);
        drive(r, ins, mr, rd, br);
        check_model();
        tick();
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{20'h03120, 1'b0, 4'd0, 1'b0, 4'b1100};
        vecs[1]  = '{20'h03120, 1'b1, 4'd1, 1'b0, 4'b0001};
        vecs[2]  = '{20'h03120, 1'b1, 4'd2, 1'b0, 4'b0001};
        vecs[3]  = '{20'h03120, 1'b1, 4'd0, 1'b0, 4'b1100};
        vecs[4]  = '{20'h03120, 1'b0, 4'd1, 1'b0, 4'b1100};
        vecs[5]  = '{20'h83120, 1'b1, 4'd2, 1'b0, 4'b1100};
        vecs[6]  = '{20'h83120, 1'b1, 4'd1, 1'b0, 4'b0001};
        vecs[7]  = '{20'hF0000, 1'b0, 4'd0, 1'b0, 4'b0001};
        vecs[8]  = '{20'hA4120, 1'b0, 4'd0, 1'b0, 4'b1100};
        vecs[9]  = '{20'hF0000, 1'b0, 4'd0, 1'b1, 4'b1111};
        vecs[10] = '{20'h03120, 1'b1, 4'd1, 1'b1, 4'b1111};
        vecs[11] = '{20'h03000, 1'b1, 4'd3, 1'b0, 4'b1100};
        vecs[12] = '{20'hA4120, 1'b1, 4'd2, 1'b0, 4'b0001};

        // First reset edge establishes a known state; nothing to compare before it.
        drive(1'b1, 20'h0, 1'b0, 4'd0, 1'b0);
        tick();

        step(1'b1, 20'h03120, 1'b0, 4'd0, 1'b0);
        chk("reset_stall_cycles", 32'(stall_cycles), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);

        for (int i = 0; i < 13; i++) begin
            step(1'b1, 20'h0, 1'b0, 4'd0, 1'b0);
            drive(1'b0, vecs[i].instr, vecs[i].mr, vecs[i].rd, vecs[i].br);
            check_model();
            chk($sformatf("vec%0d_ctl", i),
                32'({pc_write_en, ifid_write_en, ifid_flush, idex_bubble}),
                32'(vecs[i].exp_ctl));
            tick();
        end

        // Load-use costs one cycle.
        step(1'b1, 20'h0, 1'b0, 4'd0, 1'b0);
        step(1'b0, 20'h03120, 1'b1, 4'd1, 1'b0);
        drive(1'b0, 20'h03120, 1'b0, 4'd1, 1'b0);
        chk("lu_resume_pc", 32'(pc_write_en), 32'd1);
        chk("lu_stall_cycles", 32'(stall_cycles), 32'd1);
        tick();

        // MUL occupancy.
        step(1'b1, 20'h0, 1'b0, 4'd0, 1'b0);
        step(1'b0, 20'hA4120, 1'b0, 4'd0, 1'b0);
        for (int c = 0; c < MUL_CYCLES - 1; c++) begin
            drive(1'b0, 20'h03120, 1'b0, 4'd0, 1'b0);
            chk("mul_busy_on", 32'(mul_busy), 32'd1);
            chk("mul_pc_held", 32'(pc_write_en), 32'd0);
            tick();
        end
        drive(1'b0, 20'hA4120, 1'b0, 4'd0, 1'b0);
        chk("mul_done_busy", 32'(mul_busy), 32'd0);
        chk("mul_stall_cycles", 32'(stall_cycles), 32'(MUL_CYCLES - 1));
        chk("mul_back_to_back_pc", 32'(pc_write_en), 32'd1);
        tick();
        drive(1'b0, 20'h03120, 1'b0, 4'd0, 1'b0);
        chk("mul2_busy", 32'(mul_busy), 32'd1);
        check_model();
        tick();

        // Branch in MUL_BUSY squashes the drain.
        step(1'b0, 20'h03120, 1'b0, 4'd0, 1'b1);
        drive(1'b0, 20'h03120, 1'b0, 4'd0, 1'b0);
        chk("br_clears_mul", 32'(mul_busy), 32'd0);
        tick();

        // Branch beats load-use and HALT.
        step(1'b1, 20'h0, 1'b0, 4'd0, 1'b0);
        step(1'b0, 20'hF0100, 1'b1, 4'd1, 1'b1);
        drive(1'b0, 20'h03120, 1'b0, 4'd0, 1'b0);
        chk("br_no_halt", 32'(halted), 32'd0);
        tick();

        // HALT holds until reset.
        step(1'b0, 20'hF0000, 1'b0, 4'd0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, 20'h03120, 1'b0, 4'd0, c == 5);
            chk("halt_halted", 32'(halted), 32'd1);
            chk("halt_pc", 32'(pc_write_en), 32'd0);
            chk("halt_ifid", 32'(ifid_write_en), 32'd0);
            tick();
        end
        step(1'b1, 20'h03120, 1'b0, 4'd0, 1'b0);
        drive(1'b0, 20'h03120, 1'b0, 4'd0, 1'b0);
        chk("post_halt_halted", 32'(halted), 32'd0);
        chk("post_halt_stalls", 32'(stall_cycles), 32'd0);
        chk("post_halt_pc", 32'(pc_write_en), 32'd1);
        tick();

        // Randomized against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [19:0] ins;
            ins = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                   4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom)};
            step(($urandom % 60) == 0, ins, 1'($urandom), 4'($urandom_range(0, 3)),
                 ($urandom % 10) == 0);
        end

        // Saturation.
        step(1'b1, 20'h0, 1'b0, 4'd0, 1'b0);
        for (int c = 0; c < 70000; c++) begin
            drive(1'b0, 20'h03120, 1'b1, 4'd1, 1'b0);
            tick();
        end
        drive(1'b0, 20'h03120, 1'b1, 4'd1, 1'b0);
        chk("sat_stall_cycles", 32'(stall_cycles), 32'h0000FFFF);
        check_model();
        tick();
        drive(1'b0, 20'h03120, 1'b1, 4'd1, 1'b0);
        chk("sat_no_wrap", 32'(stall_cycles), 32'h0000FFFF);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard controller for the 5-stage, 20-bit-instruction core. Sits beside the IF/ID register and drives its write-enable and flush, the PC write-enable and the ID/EX bubble insert. Resolves load-use stalls, multi-cycle MUL occupancy, taken-branch squash and HALT. Also keeps a saturating stall-cycle performance counter.

## Interface
- MUL_CYCLES, 3: total EX occupancy of a MUL; legal range 2..15.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- id_instr  in  20  instruction currently held in IF/ID.
- ex_mem_read  in  1  instruction in ID/EX is a LOAD.
- ex_rd  in  4  destination register of the instruction in ID/EX.
- ex_branch_taken  in  1  branch in EX resolved taken this cycle; single-cycle pulse.
- pc_write_en  out  1  PC may advance or load the branch target.
- ifid_write_en  out  1  IF/ID captures the new fetch.
- ifid_flush  out  1  IF/ID clears to NOP (0) at the next edge.
- idex_bubble  out  1  ID/EX loads a NOP instead of the decoded ID instruction.
- mul_busy  out  1  FSM is in MUL_BUSY.
- halted  out  1  FSM is in HALTED.
- stall_cycles  out  16  count of cycles with pc_write_en=0, saturating at 16'hFFFF.

## Operation
- Decode fields of id_instr: op=[19:16], rd=[15:12], rs1=[11:8], rs2=[7:4].
- Opcodes: LOAD=4'h8, MUL=4'hA, HALT=4'hF.
- rs2 is a source operand for every opcode except LOAD and HALT.
- Register r0 never creates a hazard.
- load_use = ex_mem_read && ex_rd!=0 && (ex_rd==rs1 || (rs2 used && ex_rd==rs2)).
- FSM states: RUN, MUL_BUSY, HALTED. Internal down-counter mul_cnt is 4 bits.
- Control outputs are combinational from state and inputs. State and counters are registered.
- Per-cycle priority, highest first:
  - rst: next state RUN, mul_cnt=0, stall_cycles=0. Outputs forced to pc_write_en=0, ifid_write_en=0, ifid_flush=0, idex_bubble=1.
  - HALTED: pc_write_en=0, ifid_write_en=0, idex_bubble=1. Stays in HALTED until rst.
  - ex_branch_taken (RUN or MUL_BUSY): pc_write_en=1, ifid_write_en=1, ifid_flush=1, idex_bubble=1. Next state RUN, mul_cnt cleared. This squashes any pending stall, HALT or MUL issue decoded in ID.
  - MUL_BUSY: pc_write_en=0, ifid_write_en=0, idex_bubble=1, mul_cnt decrements. Leave to RUN on the edge where mul_cnt==1.
  - RUN && load_use: pc_write_en=0, ifid_write_en=0, idex_bubble=1 for one cycle. The next cycle re-evaluates, by which point the load has left EX.
  - RUN && op==HALT: idex_bubble=1, pc_write_en=0, ifid_write_en=0. Next state HALTED.
  - RUN && op==MUL: normal issue (all enables 1, idex_bubble=0). Next state MUL_BUSY, mul_cnt=MUL_CYCLES-1.
  - RUN otherwise: pc_write_en=1, ifid_write_en=1, ifid_flush=0, idex_bubble=0.
- ifid_flush is 1 only on the ex_branch_taken row.
- stall_cycles increments on every non-reset cycle with pc_write_en=0 and state≠HALTED (the HALT-decode cycle counts). It holds at 16'hFFFF.

## Timing
- Zero-cycle latency from inputs to control outputs. The stall is applied in the same cycle the hazard is visible.
- A load-use stall costs exactly 1 cycle. A MUL stalls the front end for MUL_CYCLES-1 cycles after its issue cycle.
- mul_busy and halted are asserted from the edge after the entering cycle. Both deassert on the edge that leaves the state.
- Reset mid-MUL or while HALTED: the next cycle after rst deasserts is RUN with counters at 0.
- Back-to-back MULs: the second MUL issues in the first RUN cycle after MUL_BUSY; there is no extra gap.
- stall_cycles is updated at the clock edge and is visible the cycle after the stall.

## Test plan
- Reset, then ADD r3,r1,r2 (20'h03120) in ID with no hazard -> pc_write_en=1, ifid_write_en=1, idex_bubble=0, stall_cycles=0.
- ex_mem_read=1, ex_rd=1, id_instr=20'h03120 -> one cycle with pc_write_en=0, ifid_write_en=0, idex_bubble=1, then normal. stall_cycles=1. Repeat with ex_rd=0 -> no stall.
- MUL (20'hA4120), MUL_CYCLES=3 -> issue cycle normal, then 2 cycles with mul_busy=1 and enables 0. stall_cycles=2, back in RUN on cycle 4.
- ex_branch_taken in the same cycle as a load_use hazard and HALT in ID -> ifid_flush=1, idex_bubble=1, pc_write_en=1, state stays RUN, halted=0.
- HALT (20'hF0000) in ID -> halted=1 next cycle, enables held 0 for 20 cycles. Then rst=1 for 1 cycle -> RUN, stall_cycles=0, halted=0.
- Force 70000 consecutive load-use cycles -> stall_cycles saturates at 16'hFFFF and does not wrap.
